// File: rtl/outpkt_arb_pkg.sv
// Shared definitions for the output packet arbiter: FSM encoding and
// default sizing constants.
package outpkt_arb_pkg;

    localparam int DIN_W             = 16;
    localparam int DEF_N_REQ         = 4;
    localparam int DEF_STALL_TIMEOUT = 1023;
    localparam int DEF_STALL_CNT_W   = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_ERROR = 2'd2
    } arb_state_t;

endpackage

// File: rtl/outpkt_arbiter_if.sv
// Bus between the packet sources, the arbiter and the output_fifo write port.
//
// Handshake: requester k offers a word on req_din[k] whenever req_empty[k]=0,
// with req_last[k] marking the final word of its packet. The word is consumed
// in the cycle where req_rd_en[k]=1. On the fifo side a word is written in
// every cycle with wr_en=1; wr_en is never raised while full=1, so full acts
// as the ready signal of the fifo.
interface outpkt_arbiter_if
    import outpkt_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
);
    logic [DIN_W*N_REQ-1:0] req_din;
    logic [N_REQ-1:0]       req_empty;
    logic [N_REQ-1:0]       req_last;
    logic [N_REQ-1:0]       req_rd_en;
    logic [DIN_W-1:0]       dout;
    logic                   wr_en;
    logic                   full;

    // Arbiter side
    modport slave (
        input  req_din, req_empty, req_last, full,
        output req_rd_en, dout, wr_en
    );

    // Sources plus fifo side
    modport master (
        output req_din, req_empty, req_last, full,
        input  req_rd_en, dout, wr_en
    );
endinterface

// File: rtl/outpkt_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: returns the first active
// request at or after ptr, wrapping modulo N_REQ.
module rr_pick
    import outpkt_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic             valid
);
    // Walk the requests starting at ptr and keep the first hit
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] sel;
        gnt   = '0;
        valid = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            sel = PTR_W'(idx);
            if (!valid && req[sel]) begin
                gnt[sel] = 1'b1;
                valid    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/outpkt_arbiter.sv
// Packet-atomic round-robin arbiter sharing the output_fifo write port among
// N_REQ sources. A grant is held for a whole packet; a granted source that
// stays empty for STALL_TIMEOUT cycles mid-packet locks the block into a
// sticky error state until RST.
// Optional feature macro: OUTPKT_ARB_STATS_EN adds per-source packet counters
// and a stall high-water mark.
module outpkt_arbiter
    import outpkt_arb_pkg::*;
#(
    parameter int N_REQ         = DEF_N_REQ,
    parameter int STALL_TIMEOUT = DEF_STALL_TIMEOUT,
    parameter int STALL_CNT_W   = DEF_STALL_CNT_W,
    localparam int PTR_W        = $clog2(N_REQ)
) (
    input  logic                    CLK,
    input  logic                    RST,
    outpkt_arbiter_if.slave         bus,
    output logic [N_REQ-1:0]        grant,
    output logic                    err_stall,
    output logic                    idle,
    output logic [PTR_W-1:0]        rr_ptr,
    output arb_state_t              fsm_state
`ifdef OUTPKT_ARB_STATS_EN
    ,
    output logic [8*N_REQ-1:0]      stats_pkt_cnt,
    output logic [STALL_CNT_W-1:0]  stats_stall_max
`endif
);

    arb_state_t             state;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic [STALL_CNT_W-1:0] stall_next;
    logic [DIN_W-1:0]       dout_mux;
    logic                   sel_empty;
    logic                   sel_last;
    logic                   write;
    logic                   stall_hit;
    logic [PTR_W-1:0]       g_idx;
    logic [PTR_W-1:0]       next_ptr;
    logic [N_REQ-1:0]       req_vec;
    logic [N_REQ-1:0]       pick_gnt;
    logic                   pick_valid;

    assign req_vec = ~bus.req_empty;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req_vec),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // Select the granted source's word and flags; an empty grant selects nothing
    always_comb begin
        dout_mux  = '0;
        sel_empty = 1'b1;
        sel_last  = 1'b0;
        g_idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                dout_mux  = bus.req_din[DIN_W*k +: DIN_W];
                sel_empty = bus.req_empty[k];
                sel_last  = bus.req_last[k];
                g_idx     = PTR_W'(k);
            end
        end
    end

    // Moves happen only in XFER, never against a full fifo
    assign write      = (state == ST_XFER) && !sel_empty && !bus.full;
    assign stall_hit  = (state == ST_XFER) && sel_empty;
    assign stall_next = stall_cnt + STALL_CNT_W'(1);
    assign next_ptr   = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + PTR_W'(1);

    assign bus.wr_en     = write;
    assign bus.req_rd_en = grant & {N_REQ{write}};
    assign bus.dout      = dout_mux;
    assign idle          = (state == ST_IDLE);
    assign fsm_state     = state;

    // Arbitration FSM: pick in IDLE, hold grant through XFER, lock in ERROR
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            err_stall <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    stall_cnt <= '0;
                    if (pick_valid) begin
                        grant <= pick_gnt;
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (write) begin
                        stall_cnt <= '0;
                        if (sel_last) begin
                            grant  <= '0;
                            rr_ptr <= next_ptr;
                            state  <= ST_IDLE;
                        end
                    end else if (stall_hit) begin
                        if (stall_cnt == STALL_CNT_W'(STALL_TIMEOUT - 1)) begin
                            stall_cnt <= '0;
                            grant     <= '0;
                            err_stall <= 1'b1;
                            state     <= ST_ERROR;
                        end else begin
                            stall_cnt <= stall_next;
                        end
                    end
                end
                ST_ERROR: begin
                    grant     <= '0;
                    err_stall <= 1'b1;
                end
                default: begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef OUTPKT_ARB_STATS_EN
    // Per-source completed-packet counters and highest stall count observed
    always_ff @(posedge CLK) begin
        if (RST) begin
            stats_pkt_cnt   <= '0;
            stats_stall_max <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (write && sel_last && grant[k]) begin
                    stats_pkt_cnt[8*k +: 8] <= stats_pkt_cnt[8*k +: 8] + 8'd1;
                end
            end
            if (stall_hit && (stall_next > stats_stall_max)) begin
                stats_stall_max <= stall_next;
            end
        end
    end
`endif

endmodule
